// File: rtl/mer_ratio_div.sv
// MER ratio divider: 26-cycle restoring division of {sig_pwr, 8'b0} by err_pwr, saturated to Q16.8.
// Optional feature macro: MER_OVERRUN_EN builds the sticky overrun flag; otherwise overrun is tied 0.
module mer_ratio_div (
  input  logic        sys_clk,
  input  logic        reset,
  input  logic        start,
  input  logic [17:0] sig_pwr,
  input  logic [17:0] err_pwr,
  output logic [23:0] mer_ratio,
  output logic        mer_valid,
  output logic        busy,
  output logic        div_zero,
  output logic        overrun
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] DIV  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]  state;
  logic [4:0]  iter;
  logic [25:0] quo;
  logic [17:0] rem;
  logic [17:0] dvs;

  logic [18:0] rem_shift;
  logic        fits;
  logic [17:0] rem_sub;
  logic [17:0] rem_next;
  logic [25:0] quo_next;

  // The dividend shifts out of quo MSB-first while quotient bits shift in at the LSB.
  // When the divisor fits, the true difference is below dvs, so 18 bits hold it exactly.
  always_comb begin
    rem_shift = {rem, quo[25]};
    fits      = (rem_shift >= {1'b0, dvs});
    rem_sub   = rem_shift[17:0] - dvs;
    rem_next  = fits ? rem_sub : rem_shift[17:0];
    quo_next  = {quo[24:0], fits};
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state     <= IDLE;
      iter      <= 5'd0;
      quo       <= 26'd0;
      rem       <= 18'd0;
      dvs       <= 18'd0;
      mer_ratio <= 24'd0;
      div_zero  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (err_pwr == 18'd0) begin
              state     <= DONE;
              mer_ratio <= 24'hFFFFFF;
              div_zero  <= 1'b1;
            end else begin
              state    <= DIV;
              quo      <= {sig_pwr, 8'h00};
              dvs      <= err_pwr;
              rem      <= 18'd0;
              iter     <= 5'd0;
              div_zero <= 1'b0;
            end
          end
        end
        DIV: begin
          quo  <= quo_next;
          rem  <= rem_next;
          iter <= iter + 5'd1;
          if (iter == 5'd25) begin
            state     <= DONE;
            mer_ratio <= (quo_next[25:24] != 2'b00) ? 24'hFFFFFF : quo_next[23:0];
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign mer_valid = (state == DONE);
  assign busy      = (state != IDLE);

`ifdef MER_OVERRUN_EN
  // Sticky until reset so software can detect a window-end pulse lost to a busy divider.
  always_ff @(posedge sys_clk) begin
    if (reset)
      overrun <= 1'b0;
    else if (start && busy)
      overrun <= 1'b1;
  end
`else
  assign overrun = 1'b0;
`endif

endmodule

// File: tb/tb_mer_ratio_div.sv
// Self-checking bench for mer_ratio_div: latency/arithmetic model plus directed literal checks.
// Honours MER_OVERRUN_EN for the expected overrun behaviour.
module tb_mer_ratio_div;

  logic        sys_clk = 1'b0;
  logic        reset;
  logic        start;
  logic [17:0] sig_pwr;
  logic [17:0] err_pwr;
  logic [23:0] mer_ratio;
  logic        mer_valid;
  logic        busy;
  logic        div_zero;
  logic        overrun;

  int n_cmp = 0;
  int n_bad = 0;

`ifdef MER_OVERRUN_EN
  localparam bit OV_EN = 1'b1;
`else
  localparam bit OV_EN = 1'b0;
`endif

  mer_ratio_div dut (
    .sys_clk  (sys_clk),
    .reset    (reset),
    .start    (start),
    .sig_pwr  (sig_pwr),
    .err_pwr  (err_pwr),
    .mer_ratio(mer_ratio),
    .mer_valid(mer_valid),
    .busy     (busy),
    .div_zero (div_zero),
    .overrun  (overrun)
  );

  always #5 sys_clk = ~sys_clk;

  // Ideal Q16.8 ratio from plain integer arithmetic, saturated to 24 bits.
  function automatic logic [23:0] ideal_ratio(input logic [17:0] s, input logic [17:0] e);
    logic [63:0] q;
    q = ({46'd0, s} * 64'd256) / {46'd0, e};
    return (q >= 64'd16777216) ? 24'hFFFFFF : q[23:0];
  endfunction

  // Model: m_left counts busy cycles still to come including the current one;
  // the result appears (and mer_valid is high) in the cycle where m_left == 1.
  int          m_left    = 0;
  logic [23:0] m_ratio   = '0;
  logic [23:0] m_pending = '0;
  logic        m_dz      = 1'b0;
  logic        m_ov      = 1'b0;
  bit          cmp_en    = 1'b0;

  always @(posedge sys_clk) begin
    if (reset) begin
      m_left  = 0;
      m_ratio = '0;
      m_dz    = 1'b0;
      m_ov    = 1'b0;
    end else if (m_left == 0) begin
      if (start) begin
        if (err_pwr == 18'd0) begin
          m_left  = 1;
          m_ratio = 24'hFFFFFF;
          m_dz    = 1'b1;
        end else begin
          m_left    = 27;
          m_pending = ideal_ratio(sig_pwr, err_pwr);
          m_dz      = 1'b0;
        end
      end
    end else begin
      if (start && OV_EN) m_ov = 1'b1;
      m_left = m_left - 1;
      if (m_left == 1) m_ratio = m_pending;
    end
  end

  task automatic checkOutput(input string name, input logic [23:0] act, input logic [23:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge sys_clk) begin
    if (cmp_en) begin
      checkOutput("model mer_ratio", mer_ratio, m_ratio);
      checkOutput("model mer_valid", {23'd0, mer_valid}, {23'd0, (m_left == 1)});
      checkOutput("model busy", {23'd0, busy}, {23'd0, (m_left > 0)});
      checkOutput("model div_zero", {23'd0, div_zero}, {23'd0, m_dz});
      checkOutput("model overrun", {23'd0, overrun}, {23'd0, m_ov});
    end
  end

  // Drives one cycle of inputs just after a rising edge, returns mid-cycle.
  task automatic applyStimulus(input logic rs, input logic st, input logic [17:0] sp, input logic [17:0] ep);
    @(posedge sys_clk);
    #1;
    reset   = rs;
    start   = st;
    sig_pwr = sp;
    err_pwr = ep;
    @(negedge sys_clk);
  endtask

  // Starts a run in cycle 0, presents different operands afterwards, and checks literal expectations.
  task automatic run_case(input logic [17:0] sp, input logic [17:0] ep,
                          input logic [17:0] sp2, input logic [17:0] ep2,
                          input int lat, input logic [23:0] exp_ratio, input logic exp_dz);
    applyStimulus(1'b0, 1'b1, sp, ep);
    for (int k = 1; k <= lat; k++) begin
      applyStimulus(1'b0, 1'b0, sp2, ep2);
      checkOutput("run busy", {23'd0, busy}, 24'd1);
      if (k == lat) begin
        checkOutput("run mer_valid at latency", {23'd0, mer_valid}, 24'd1);
        checkOutput("run mer_ratio", mer_ratio, exp_ratio);
        checkOutput("run div_zero", {23'd0, div_zero}, {23'd0, exp_dz});
      end else begin
        checkOutput("run early mer_valid", {23'd0, mer_valid}, 24'd0);
      end
    end
    applyStimulus(1'b0, 1'b0, sp2, ep2);
    checkOutput("run idle busy", {23'd0, busy}, 24'd0);
    checkOutput("run idle mer_valid", {23'd0, mer_valid}, 24'd0);
    checkOutput("run hold mer_ratio", mer_ratio, exp_ratio);
  endtask

  initial begin
    reset   = 1'b1;
    start   = 1'b0;
    sig_pwr = '0;
    err_pwr = '0;
    applyStimulus(1'b1, 1'b0, 18'd0, 18'd0);
    cmp_en = 1'b1;
    checkOutput("reset mer_ratio", mer_ratio, 24'd0);
    checkOutput("reset mer_valid", {23'd0, mer_valid}, 24'd0);
    checkOutput("reset busy", {23'd0, busy}, 24'd0);
    checkOutput("reset div_zero", {23'd0, div_zero}, 24'd0);
    checkOutput("reset overrun", {23'd0, overrun}, 24'd0);

    // Reset wins over a simultaneous start.
    applyStimulus(1'b1, 1'b1, 18'd5, 18'd1);
    applyStimulus(1'b0, 1'b0, 18'd0, 18'd0);
    checkOutput("reset priority busy", {23'd0, busy}, 24'd0);

    $display("[TB] basic ratios");
    run_case(18'd65536, 18'd256, 18'd1, 18'd1, 27, 24'h010000, 1'b0);
    run_case(18'd3, 18'd2, 18'd7, 18'd9, 27, 24'h000180, 1'b0);
    run_case(18'd12345, 18'd678, 18'd0, 18'd0, 27, 24'h001235, 1'b0);

    $display("[TB] divide by zero and saturation");
    run_case(18'd1000, 18'd0, 18'd0, 18'd0, 1, 24'hFFFFFF, 1'b1);
    run_case(18'd1000, 18'd4, 18'd0, 18'd0, 27, 24'h00FA00, 1'b0);
    run_case(18'h3FFFF, 18'd1, 18'd0, 18'd0, 27, 24'hFFFFFF, 1'b0);

    $display("[TB] start while busy");
    applyStimulus(1'b0, 1'b1, 18'd3, 18'd2);
    for (int k = 1; k <= 27; k++) begin
      applyStimulus(1'b0, (k == 10), 18'd500, 18'd7);
      if (k < 27) checkOutput("overrun early mer_valid", {23'd0, mer_valid}, 24'd0);
    end
    checkOutput("overrun mer_valid", {23'd0, mer_valid}, 24'd1);
    checkOutput("overrun mer_ratio", mer_ratio, 24'h000180);
    applyStimulus(1'b0, 1'b0, 18'd500, 18'd7);
    checkOutput("overrun no extra valid", {23'd0, mer_valid}, 24'd0);
    checkOutput("overrun flag", {23'd0, overrun}, {23'd0, OV_EN});

    $display("[TB] reset mid-division");
    applyStimulus(1'b0, 1'b1, 18'd1000, 18'd3);
    for (int k = 1; k <= 11; k++) applyStimulus(1'b0, 1'b0, 18'd1000, 18'd3);
    applyStimulus(1'b1, 1'b0, 18'd1000, 18'd3);
    applyStimulus(1'b0, 1'b0, 18'd1000, 18'd3);
    checkOutput("abort mer_ratio", mer_ratio, 24'd0);
    checkOutput("abort mer_valid", {23'd0, mer_valid}, 24'd0);
    checkOutput("abort busy", {23'd0, busy}, 24'd0);
    checkOutput("abort div_zero", {23'd0, div_zero}, 24'd0);
    checkOutput("abort overrun", {23'd0, overrun}, 24'd0);
    for (int k = 14; k <= 30; k++) begin
      applyStimulus(1'b0, 1'b0, 18'd1000, 18'd3);
      checkOutput("abort no valid", {23'd0, mer_valid}, 24'd0);
    end
    run_case(18'd1000, 18'd3, 18'd2, 18'd2, 27, 24'h014D55, 1'b0);

    applyStimulus(1'b0, 1'b0, 18'd0, 18'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mer_ratio_div.md
MER_RATIO_DIV -- requirements
Module: mer_ratio_div

Interface
REQ-001 SHALL have port sys_clk  input  1  system clock; all state changes on its rising edge.
REQ-002 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have port start  input  1  one-cycle strobe at the end of the MER accumulation window; driven by the window-end "cycle" pulse.
REQ-004 SHALL have port sig_pwr  input  18  unsigned mean decision-variable power, from the map_out_pwr average.
REQ-005 SHALL have port err_pwr  input  18  unsigned mean squared error, from the error-square average.
REQ-006 SHALL have port mer_ratio  output  24  unsigned MER ratio sig_pwr/err_pwr in format 16 integer bits . 8 fraction bits.
REQ-007 SHALL have port mer_valid  output  1  one-cycle pulse when mer_ratio updates.
REQ-008 SHALL have port busy  output  1  high while a division is in progress.
REQ-009 SHALL have port div_zero  output  1  high when the latest result came from err_pwr == 0.
REQ-010 SHALL have port overrun  output  1  sticky flag: start arrived while busy.

Function
REQ-011 SHALL implement states IDLE, DIV, DONE; the reset state is IDLE.
REQ-012 In IDLE with start=1 and err_pwr!=0, SHALL capture dividend = {sig_pwr, 8'b0} (26 bits) and divisor = err_pwr, clear the 5-bit iteration counter, and go to DIV.
REQ-013 In DIV, SHALL perform one restoring-division step per sys_clk (one quotient bit, MSB first) for exactly 26 cycles, then go to DONE.
REQ-014 On the DIV->DONE edge, SHALL load mer_ratio with the 26-bit quotient saturated to 24 bits: any quotient >= 2^24 gives 24'hFFFFFF.
REQ-015 SHALL hold mer_valid=1 for the single DONE cycle, then return to IDLE.
REQ-016 Latency: if start is high in cycle 0, SHALL have DIV in cycles 1-26 and mer_valid high in cycle 27.
REQ-017 In IDLE with start=1 and err_pwr==0, SHALL go directly to DONE, load mer_ratio=24'hFFFFFF and set div_zero=1; mer_valid is then high in cycle 1.
REQ-018 SHALL clear div_zero on any start that has err_pwr!=0.
REQ-019 SHALL assert busy in DIV and DONE, and deassert it in IDLE.
REQ-020 SHALL ignore start in DIV or DONE: operands and quotient stay undisturbed and overrun is set (see REQ-026).
REQ-021 SHALL hold mer_ratio stable between mer_valid pulses.
REQ-022 SHALL sample operands only at the start edge; later changes to sig_pwr and err_pwr SHALL NOT affect the running division.

Reset
REQ-023 reset=1 SHALL force IDLE and set mer_ratio=0, mer_valid=0, busy=0, div_zero=0, overrun=0, and clear the counter and working registers on the next sys_clk edge.
REQ-024 reset SHALL take priority over start in the same cycle.
REQ-025 reset mid-DIV SHALL abort the division with no mer_valid; the next start after reset SHALL run normally.

Configuration
REQ-026 With macro MER_OVERRUN_EN defined: overrun SHALL be a sticky register, set by start during busy and cleared only by reset.
REQ-027 Without MER_OVERRUN_EN: overrun SHALL be tied 0 and no overrun logic is built; start during busy is still ignored.

Verification
REQ-028 sig_pwr=65536, err_pwr=256, start in cycle 0 -> busy in cycles 1-27, mer_valid only in cycle 27, mer_ratio=24'h010000, div_zero=0.
REQ-029 sig_pwr=3, err_pwr=2 -> mer_ratio=24'h000180 (1.5) at cycle 27.
REQ-030 sig_pwr=1000, err_pwr=0 -> mer_valid in cycle 1, mer_ratio=24'hFFFFFF, div_zero=1; a following run with err_pwr=4 clears div_zero.
REQ-031 sig_pwr=18'h3FFFF, err_pwr=1 -> saturated mer_ratio=24'hFFFFFF, div_zero=0.
REQ-032 Second start in cycle 10 with changed operands -> first result unchanged at cycle 27, no extra mer_valid; overrun=1 if MER_OVERRUN_EN, else 0.
REQ-033 reset in cycle 12 of a division -> all outputs 0 in cycle 13 and no mer_valid; a new start then yields the correct result 27 cycles later.
